fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch controller for the pipelined MIPS core. It sits between the PC register and the ID stage. It drives the PC register's `next_pc`/`en`, issues one instruction-memory request per PC over a variable-latency request/valid handshake, and owns the IF/ID pipeline register. It handles ID stalls, branch/jump redirects resolved in ID with the architectural delay slot, and buffering of a returned instruction while ID is stalled.

## Interface
Parameters:
- `RESET_PC`, default 32'h00003000: PC value after reset; also the reset value of `D_pc`.

Ports:
- `clk`, in, 1: single clock; all state updates on posedge.
- `reset`, in, 1: synchronous, active-high.
- `pc`, in, 32: current PC from the PC register.
- `next_pc`, out, 32: next PC to the PC register (combinational).
- `pc_en`, out, 1: PC register write enable (combinational).
- `imem_req`, out, 1: one-cycle fetch request pulse.
- `imem_addr`, out, 32: fetch address; equals `pc`.
- `imem_rvalid`, in, 1: response valid.
- `imem_rdata`, in, 32: instruction word; valid with `imem_rvalid`.
- `id_stall`, in, 1: ID cannot accept a new instruction; hold IF/ID.
- `redirect`, in, 1: branch taken or jump in ID. Sampled only when `id_stall`=0.
- `redirect_target`, in, 32: target address, valid with `redirect`.
- `D_instr`, out, 32: IF/ID instruction.
- `D_pc`, out, 32: IF/ID instruction address.
- `D_pc8`, out, 32: `D_pc`+8 (link address).
- `D_valid`, out, 1: IF/ID holds a real instruction (0 = bubble).

## Operation
- States: ISSUE, WAIT, HOLD. Reset state is ISSUE.
- ISSUE:
  - `imem_req`=1, `imem_addr`=`pc`.
  - Go to WAIT.
- WAIT:
  - No request is issued.
  - On `imem_rvalid` with `id_stall`=0: load IF/ID with {`imem_rdata`, `pc`, `pc`+8}, set `D_valid`=1, assert `pc_en`, go to ISSUE.
  - On `imem_rvalid` with `id_stall`=1: capture `imem_rdata` into the hold buffer, go to HOLD.
- HOLD:
  - When `id_stall`=0: load IF/ID from the hold buffer (with `pc`, `pc`+8), set `D_valid`=1, assert `pc_en`, go to ISSUE.
- Bubble rule: in any cycle where `id_stall`=0 and no instruction is loaded, `D_valid` goes to 0. `D_instr`, `D_pc` and `D_pc8` keep their old values.
- Stall rule: while `id_stall`=1, all IF/ID outputs hold.
- `imem_rvalid` is ignored in ISSUE and HOLD.
- Next-PC selection when `pc_en`=1, in priority order:
  1. Pending redirect → `pending_target`.
  2. Same-cycle `redirect` with `id_stall`=0 → `redirect_target`.
  3. Otherwise `pc`+4.
- When `pc_en`=0, `next_pc` = `pc+4` (don't-care).
- Delay slot: the instruction being fetched when `redirect` arrives is the delay slot and is never discarded. The redirect affects only the PC after it.
- Pending latch:
  - `redirect` with `id_stall`=0 and `pc_en`=0 sets `pending_valid` and stores `pending_target`.
  - The latch is cleared on the next `pc_en`.
  - A second redirect while pending overwrites the target (illegal program order; no error flag).
- Arithmetic: `pc`+4 and `pc`+8 are 32-bit and wrap modulo 2^32. Alignment is not checked.

## Timing
- Reset values:
  - state=ISSUE, `D_valid`=0, `D_instr`=0, `D_pc`=`RESET_PC`, `D_pc8`=`RESET_PC`+8, `pending_valid`=0, hold buffer=0.
  - `imem_req` is not asserted during a cycle with `reset`=1.
- Fetch latency: request at cycle t, response at t+L with L≥1. IF/ID loads at the edge ending the response cycle. The next request goes out one cycle after that.
- Peak throughput is one instruction per L+1 cycles.
- Stall plus response in the same cycle: the instruction goes to HOLD. It is released on the first edge where `id_stall`=0, with zero added latency.
- Redirect in the same cycle as `pc_en`: the target takes effect at that edge, and the PC register holds the target on the next cycle.
- Reset mid-fetch: the outstanding request is abandoned. Imem is reset by the same `reset`. A stale `imem_rvalid` arriving in ISSUE is ignored.

## Structure
- Shared package `fetch_pkg`:
  - state enum `fetch_state_t` {ISSUE, WAIT, HOLD}
  - `RESET_PC_DEFAULT`
  - `INSTR_NOP`=32'h0
- Sub-module `if_id_reg`: IF/ID pipeline register with load, clear-valid and hold controls, plus the `D_pc8` adder.
- FSM, hold buffer, pending latch and next-PC mux live in `fetch_ctrl`.

## Test plan
- Reset, then L=1 memory returning `instr = addr ^ 32'hA5A5_0000`, no stalls → first `imem_req` at addr 0x3000. `D_pc` then steps 0x3000, 0x3004, 0x3008, one load every 2 cycles. `D_valid` alternates 1/0.
- Response arrives with `id_stall`=1 for 3 cycles → `D_*` unchanged and state HOLD. On stall release, `D_instr` = buffered word and `D_pc`=0x3004. No extra `imem_req` during the stall.
- `redirect`=1, target=0x3100, asserted while WAIT for 0x3008 → 0x3008 is delivered as the delay slot. The next `imem_addr` is 0x3100, and `pending_valid` clears.
- `redirect` coinciding with the delivery of 0x3008 → `next_pc`=0x3100 in that cycle.
- `redirect` with `id_stall`=1 → ignored, and fetch continues sequentially.
- Reset asserted in WAIT with L=4, stale `imem_rvalid` one cycle after release → response ignored. `D_valid`=0, the first request goes to 0x3000, and `D_pc` stays 0x3000.
- `pc`=32'hFFFF_FFFC delivered → `D_pc8`=32'h0000_0004 and `next_pc`=0 (wrap).

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

    // Fetch FSM states: ISSUE sends the request, WAIT waits for the memory,
    // HOLD parks a returned word while ID is stalled.
    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;

    // Sequential step and link offset; both wrap modulo 2^32.
    localparam logic [31:0] PC_STEP     = 32'd4;
    localparam logic [31:0] LINK_OFFSET = 32'd8;

    function automatic logic [31:0] pc_plus(input logic [31:0] base,
                                            input logic [31:0] offset);
        return base + offset;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bundle of fetch-controller signals: PC register, instruction memory, IF/ID.
// Latency: n/a (wires only).
// Backpressure: id_stall from ID, imem request/valid handshake to memory.
//
// master = fetch controller, slave = environment (PC register, imem, ID).
// dbg_state / dbg_pending_valid expose internal status for observation.
interface fetch_ctrl_if;
    import fetch_pkg::*;

    // PC register
    logic [31:0]  pc;
    logic [31:0]  next_pc;
    logic         pc_en;
    // Instruction memory
    logic         imem_req;
    logic [31:0]  imem_addr;
    logic         imem_rvalid;
    logic [31:0]  imem_rdata;
    // ID stage control
    logic         id_stall;
    logic         redirect;
    logic [31:0]  redirect_target;
    // IF/ID register
    logic [31:0]  D_instr;
    logic [31:0]  D_pc;
    logic [31:0]  D_pc8;
    logic         D_valid;
    // Status
    fetch_state_t dbg_state;
    logic         dbg_pending_valid;

    modport master (
        input  pc, imem_rvalid, imem_rdata, id_stall, redirect, redirect_target,
        output next_pc, pc_en, imem_req, imem_addr,
        output D_instr, D_pc, D_pc8, D_valid,
        output dbg_state, dbg_pending_valid
    );

    modport slave (
        output pc, imem_rvalid, imem_rdata, id_stall, redirect, redirect_target,
        input  next_pc, pc_en, imem_req, imem_addr,
        input  D_instr, D_pc, D_pc8, D_valid,
        input  dbg_state, dbg_pending_valid
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load / clear-valid / hold control and link adder.
// Latency: 1 cycle from load_i to outputs.
// Backpressure: holds all outputs whenever neither load_i nor clr_valid_i is set.
//
// Ports: clk_i, reset_i (sync, active-high); load_i captures instr_i/pc_i and
// sets valid; clr_valid_i inserts a bubble keeping the data fields; outputs
// instr_o, pc_o, pc8_o (= pc_o + 8) and valid_o.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        load_i,
    input  logic        clr_valid_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc8_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q,    pc_d;
    logic [31:0] pc8_q,   pc8_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        pc8_d   = pc8_q;
        valid_d = valid_q;
        if (load_i) begin
            instr_d = instr_i;
            pc_d    = pc_i;
            pc8_d   = pc_plus(pc_i, LINK_OFFSET);
            valid_d = 1'b1;
        end else if (clr_valid_i) begin
            // Bubble: only the valid bit drops, data fields keep their values.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            instr_q <= INSTR_NOP;
            pc_q    <= RESET_PC;
            pc8_q   <= pc_plus(RESET_PC, LINK_OFFSET);
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc8_q   <= pc8_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign pc8_o   = pc8_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: one imem request per PC, IF/ID ownership, redirects.
// Latency: request at t, response at t+L, IF/ID loads at end of t+L, next request t+L+1.
// Backpressure: id_stall parks a returned word in a hold buffer; no new request until delivered.
//
// Ports: clk, reset (sync, active-high), bus (fetch_ctrl_if.master) carrying the
// PC register interface, imem request/response, ID stall/redirect and IF/ID outputs.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.master bus
);

    fetch_state_t state_q, state_d;
    logic [31:0]  hold_q, hold_d;
    logic         pend_vld_q, pend_vld_d;
    logic [31:0]  pend_tgt_q, pend_tgt_d;

    logic         req;
    logic         load;
    logic         clr_valid;
    logic         pc_en;
    logic         take_redirect;
    logic [31:0]  load_instr;
    logic [31:0]  pc_inc;
    logic [31:0]  next_pc;

    // Redirects are only meaningful when ID actually advances.
    assign take_redirect = bus.redirect && !bus.id_stall;
    assign pc_inc        = pc_plus(bus.pc, PC_STEP);

    // FSM next-state and IF/ID control
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        req        = 1'b0;
        load       = 1'b0;
        pc_en      = 1'b0;
        load_instr = hold_q;
        unique case (state_q)
            ISSUE: begin
                // No request while reset is held; the memory is being reset too.
                req     = !reset;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    if (!bus.id_stall) begin
                        load       = 1'b1;
                        load_instr = bus.imem_rdata;
                        pc_en      = 1'b1;
                        state_d    = ISSUE;
                    end else begin
                        hold_d  = bus.imem_rdata;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Released on the first unstalled edge with no extra latency.
                if (!bus.id_stall) begin
                    load    = 1'b1;
                    pc_en   = 1'b1;
                    state_d = ISSUE;
                end
            end
            default: state_d = ISSUE;
        endcase
    end

    // Any unstalled cycle that does not load becomes a bubble in ID.
    assign clr_valid = !bus.id_stall && !load;

    // Next-PC: a redirect seen earlier in this fetch beats one arriving now;
    // both beat sequential flow. The word being delivered is the delay slot.
    always_comb begin
        next_pc = pc_inc;
        if (pc_en) begin
            if (pend_vld_q) begin
                next_pc = pend_tgt_q;
            end else if (take_redirect) begin
                next_pc = bus.redirect_target;
            end
        end
    end

    // Pending redirect latch: remembers a redirect that arrived while the PC
    // could not advance; a later one overwrites the target.
    always_comb begin
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;
        if (pc_en) begin
            pend_vld_d = 1'b0;
        end else if (take_redirect) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = bus.redirect_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ISSUE;
            hold_q     <= INSTR_NOP;
            pend_vld_q <= 1'b0;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            pend_vld_q <= pend_vld_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    if_id_reg #(
        .RESET_PC (RESET_PC)
    ) u_if_id (
        .clk_i       (clk),
        .reset_i     (reset),
        .load_i      (load),
        .clr_valid_i (clr_valid),
        .instr_i     (load_instr),
        .pc_i        (bus.pc),
        .instr_o     (bus.D_instr),
        .pc_o        (bus.D_pc),
        .pc8_o       (bus.D_pc8),
        .valid_o     (bus.D_valid)
    );

    assign bus.imem_req          = req;
    assign bus.imem_addr         = bus.pc;
    assign bus.pc_en             = pc_en;
    assign bus.next_pc           = next_pc;
    assign bus.dbg_state         = state_q;
    assign bus.dbg_pending_valid = pend_vld_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC register and variable-latency imem modelled here,
// a transaction-level reference model predicts deliveries and next PCs.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_ctrl_if bus ();

    fetch_ctrl #(
        .RESET_PC (32'h0000_3000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // PC register
    always @(posedge clk) begin
        if (reset)          bus.pc <= 32'h0000_3000;
        else if (bus.pc_en) bus.pc <= bus.next_pc;
    end

    // Instruction memory: answers L cycles after a request, word = addr ^ A5A5_0000
    int          mem_lat = 1;
    logic [2:0]  cnt     = '0;
    logic [31:0] paddr   = '0;
    logic        inj     = 1'b0;
    logic        inj_req = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (bus.imem_req) begin
            cnt   <= 3'(mem_lat);
            paddr <= bus.imem_addr;
        end else if (cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
        end
    end
    assign bus.imem_rvalid = (cnt == 3'd1) || inj;
    assign bus.imem_rdata  = paddr ^ 32'hA5A5_0000;

    // Reference model: address of the instruction being fetched, whether its
    // request is out / its word has come back, the redirect seen during this
    // fetch, and the IF/ID contents expected after the coming edge.
    logic [31:0] m_fetch, m_tgt, e_instr, e_pc, e_pc8;
    logic        m_inflight, m_ready, m_win, e_valid;
    int          n_deliv = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_fetch    = 32'h0000_3000;
        e_instr    = 32'h0;
        e_pc       = 32'h0000_3000;
        e_pc8      = 32'h0000_3008;
        e_valid    = 1'b0;
        m_inflight = 1'b0;
        m_ready    = 1'b0;
        m_win      = 1'b0;
        m_tgt      = 32'h0;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset               = 1'b1;
            inj                 = 1'b0;
            bus.id_stall        = 1'b0;
            bus.redirect        = 1'b0;
            bus.redirect_target = 32'h0;
            #1;
            chk("req_in_reset", 32'(bus.imem_req), 32'd0);
        end
        model_reset();
    endtask

    // One clock cycle: drive inputs, check registered outputs against the
    // model, check combinational outputs, then advance the model.
    task automatic tick(input logic stall, input logic redir, input logic [31:0] tgt);
        logic        rv;
        logic        deliver;
        logic [31:0] nxt;
        @(negedge clk);
        reset               = 1'b0;
        inj                 = inj_req;
        inj_req             = 1'b0;
        bus.id_stall        = stall;
        bus.redirect        = redir;
        bus.redirect_target = tgt;
        #1;
        chk("D_valid", 32'(bus.D_valid), 32'(e_valid));
        chk("D_pc",    bus.D_pc,    e_pc);
        chk("D_pc8",   bus.D_pc8,   e_pc8);
        chk("D_instr", bus.D_instr, e_instr);
        chk("imem_req", 32'(bus.imem_req), 32'(!m_inflight));
        if (!m_inflight) chk("imem_addr", bus.imem_addr, m_fetch);
        rv = bus.imem_rvalid;
        // A response only counts for a request that is actually out.
        if (m_inflight) begin
            if (rv) m_ready = 1'b1;
        end else begin
            m_inflight = 1'b1;
        end
        if (redir && !stall) begin
            m_win = 1'b1;
            m_tgt = tgt;
        end
        deliver = m_ready && !stall;
        chk("pc_en", 32'(bus.pc_en), 32'(deliver));
        if (deliver) begin
            nxt = m_win ? m_tgt : m_fetch + 32'd4;
            chk("next_pc", bus.next_pc, nxt);
            e_valid    = 1'b1;
            e_pc       = m_fetch;
            e_pc8      = m_fetch + 32'd8;
            e_instr    = m_fetch ^ 32'hA5A5_0000;
            m_fetch    = nxt;
            m_inflight = 1'b0;
            m_ready    = 1'b0;
            m_win      = 1'b0;
            n_deliv++;
        end else if (!stall) begin
            e_valid = 1'b0;
        end
    endtask

    initial begin
        int          start_deliv;
        logic        st;
        logic        rd;
        logic [31:0] tg;

        bus.id_stall        = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = 32'h0;

        // Reset values and L=1 sequential stream
        do_reset(2);
        mem_lat = 1;
        tick(0, 0, 0);
        chk("first_req", 32'(bus.imem_req), 32'd1);
        chk("first_addr", bus.imem_addr, 32'h0000_3000);
        chk("reset_D_pc8", bus.D_pc8, 32'h0000_3008);
        for (int i = 0; i < 6; i++) tick(0, 0, 0);
        chk("seq_D_pc", bus.D_pc, 32'h0000_3008);
        chk("seq_D_valid", 32'(bus.D_valid), 32'd1);
        tick(0, 0, 0);
        chk("seq_bubble", 32'(bus.D_valid), 32'd0);

        // Response during a 3-cycle stall goes to HOLD, released with no extra latency
        do_reset(1);
        mem_lat = 1;
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        tick(1, 0, 0);
        tick(1, 0, 0);
        chk("hold_state", 32'(bus.dbg_state), 32'(HOLD));
        chk("hold_no_req", 32'(bus.imem_req), 32'd0);
        chk("hold_D_pc", bus.D_pc, 32'h0000_3000);
        tick(1, 0, 0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("release_D_pc", bus.D_pc, 32'h0000_3004);
        chk("release_D_instr", bus.D_instr, 32'h0000_3004 ^ 32'hA5A5_0000);

        // Redirect while waiting for 0x3008 (L=3): delay slot kept, pending used
        do_reset(1);
        mem_lat = 3;
        for (int i = 0; i < 9; i++) tick(0, 0, 0);
        tick(0, 1, 32'h0000_3100);
        tick(0, 0, 0);
        chk("pending_set", 32'(bus.dbg_pending_valid), 32'd1);
        tick(0, 0, 0);
        chk("pending_next_pc", bus.next_pc, 32'h0000_3100);
        tick(0, 0, 0);
        chk("delay_slot_pc", bus.D_pc, 32'h0000_3008);
        chk("target_addr", bus.imem_addr, 32'h0000_3100);
        chk("pending_clear", 32'(bus.dbg_pending_valid), 32'd0);

        // Redirect in the same cycle as delivery of 0x3008
        do_reset(1);
        mem_lat = 1;
        for (int i = 0; i < 5; i++) tick(0, 0, 0);
        tick(0, 1, 32'h0000_3200);
        chk("same_cycle_next_pc", bus.next_pc, 32'h0000_3200);
        tick(0, 0, 0);
        chk("same_cycle_addr", bus.imem_addr, 32'h0000_3200);

        // Redirect under stall is ignored
        do_reset(1);
        mem_lat = 1;
        tick(0, 0, 0);
        tick(1, 1, 32'h0000_3300);
        tick(0, 0, 0);
        chk("stalled_redir_next_pc", bus.next_pc, 32'h0000_3004);
        tick(0, 0, 0);
        chk("stalled_redir_addr", bus.imem_addr, 32'h0000_3004);

        // Reset mid-WAIT with L=4, stale response right after release
        do_reset(1);
        mem_lat = 4;
        tick(0, 0, 0);
        tick(0, 0, 0);
        do_reset(2);
        inj_req = 1'b1;
        tick(0, 0, 0);
        chk("stale_req_addr", bus.imem_addr, 32'h0000_3000);
        chk("stale_D_valid", 32'(bus.D_valid), 32'd0);
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("stale_D_pc", bus.D_pc, 32'h0000_3000);
        chk("stale_D_valid2", 32'(bus.D_valid), 32'd0);
        for (int i = 0; i < 4; i++) tick(0, 0, 0);

        // Wrap at the top of the address space
        do_reset(1);
        mem_lat = 1;
        tick(0, 0, 0);
        tick(0, 1, 32'hFFFF_FFFC);
        chk("wrap_redir", bus.next_pc, 32'hFFFF_FFFC);
        tick(0, 0, 0);
        chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        tick(0, 0, 0);
        chk("wrap_next_pc", bus.next_pc, 32'h0000_0000);
        tick(0, 0, 0);
        chk("wrap_D_pc", bus.D_pc, 32'hFFFF_FFFC);
        chk("wrap_D_pc8", bus.D_pc8, 32'h0000_0004);

        // Random latency, stalls and redirects against the model
        do_reset(1);
        start_deliv = n_deliv;
        for (int i = 0; i < 800; i++) begin
            if (!m_inflight) mem_lat = int'($urandom_range(1, 4));
            st = ($urandom_range(0, 9) < 3);
            rd = !m_win && ($urandom_range(0, 7) == 0);
            tg = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) tg = 32'hFFFF_FFF8;
            tick(st, rd, tg);
        end
        chk("random_progress", 32'(n_deliv - start_deliv > 60), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
